mux_rr_scheduler: RTL
=====================

# mux_rr_scheduler

Round-robin scheduler that shares one 8:1 single-bit multiplexer (the `m81` datapath) between eight requesters. It arbitrates among pending requests, holds the winner's select lines for a burst of up to BURST handshaked beats, and then rotates priority. The block sits in front of the mux, drives S2..S0, and presents the selected bit to a downstream consumer over a valid/ready handshake.

## Interface

Parameters:
- BURST, default 4: maximum accepted beats per grant; legal range 1..15.
- CNT_W, default 4: width of the beat counter; must satisfy 2^CNT_W > BURST.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  level request per source; req[i] high means source i has a bit to send.
- d  input  8  data bit per source; d[i] is source i's current bit.
- sel  output  3  registered mux select {S2,S1,S0} = index of the granted source.
- gnt  output  8  registered one-hot grant; all zero when idle.
- dout  output  1  combinational d[sel], equivalent to the m81 output.
- out_valid  output  1  combinational; high when a beat is offered.
- out_ready  input  1  downstream accepts the beat when high together with out_valid.
- busy  output  1  registered; high while a grant is held.

## Operation

- Two-state FSM: IDLE, BUSY.
- Registered state: state, sel[2:0], gnt[7:0], ptr[2:0] (highest-priority index), cnt[CNT_W-1:0].
- Reset values: state=IDLE, sel=0, gnt=0, ptr=0, cnt=0, busy=0. The combinational outputs follow from these: out_valid=0, dout=d[0].
- IDLE:
  - gnt=0, out_valid=0.
  - If req is nonzero, choose the first index i with req[i]=1, scanning ptr, ptr+1, ... mod 8.
  - At the next edge: sel<=i, gnt<=1<<i, cnt<=0, busy<=1, state<=BUSY.
  - If req is zero, all state holds.
- BUSY:
  - out_valid = req[sel]; dout = d[sel].
  - Beat accepted = out_valid & out_ready; each accepted beat increments cnt.
  - Release condition, evaluated in the current cycle:
    - (a) beat accepted and cnt==BURST-1, or
    - (b) req[sel]==0 (source dropped its request; no beat this cycle).
  - On release, at the next edge: state<=IDLE, gnt<=0, busy<=0, cnt<=0, ptr<=sel+1 mod 8 (wraps 7->0). sel holds its last value.
  - Otherwise hold; cnt holds when no beat is accepted (backpressure).
- Requests from non-granted sources are ignored in BUSY. They have no effect on the current grant.
- A requester deasserting and reasserting within one grant is treated as a drop (case b). It competes again in IDLE.
- Width rule: ptr and sel arithmetic is modulo 8, so 7+1 yields 0.
- Reset mid-burst: outputs go to reset values immediately (asynchronously). The partial burst is abandoned, with no beat counted.

## Timing

- Arbitration latency: req sampled at edge k produces gnt/sel/busy valid after edge k, and out_valid is high in that same cycle. That is one cycle from request to first offered beat.
- With out_ready held at 1 and req held, BURST=4: beats are accepted at edges k+1..k+4. State is IDLE after edge k+4. The next grant is registered at edge k+5 at the earliest.
- One mandatory idle cycle occurs between consecutive grants, including back-to-back grants to different sources.
- sel is stable for the whole grant. dout changes only when d[sel] changes.
- out_valid may fall mid-grant only via req[sel] dropping. That same cycle is the release cycle.

## Test plan

- Reset: assert rst mid-burst (cnt=2), async -> gnt=0, busy=0, out_valid=0, sel=0 immediately. After release, req=8'h08 -> grant to 3 one cycle later.
- Single source, BURST=4, req=8'h04, d[2]=1, out_ready=1 -> sel=2, gnt=8'h04, four beats with dout=1, then one idle cycle, then regrant to 2.
- Round robin: req=8'hFF held, out_ready=1 -> grant order 0,1,2,...,7,0. Each grant gives exactly 4 beats and is separated by 1 idle cycle. ptr wraps after 7.
- Backpressure: grant to 5, out_ready pattern 1,0,0,1,1,0,1 -> cnt advances only on the 1s. Release follows the 4th accepted beat (7 BUSY cycles).
- Early drop: grant to 6, req[6] falls after 2 beats -> out_valid=0 that cycle, release. ptr=7, so with req=8'h81 the next grant goes to 7 (the only requester at or after ptr).
- Contention priority: ptr=6, req=8'h41 -> grant 6. After release, with req=8'h41 still asserted, the next grant goes to 0 (7 idle, wrap to 0).

Source files
------------

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler that shares one 8:1 single-bit mux between eight requesters.
// A grant is held for up to BURST accepted beats, then priority rotates past the winner.
module mux_rr_scheduler #(
  parameter int BURST = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       dout,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_n;
  logic [2:0]       ptr, ptr_n, sel_n, pick;
  logic [7:0]       gnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, found, accept, last_beat;

  // Scan upward from ptr with modulo-8 wrap; the first requester seen wins.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!found && req[ptr + 3'(k)]) begin
        pick  = ptr + 3'(k);
        found = 1'b1;
      end
    end
  end

  assign dout      = d[sel];
  assign out_valid = (state == BUSY) && req[sel];
  assign accept    = out_valid && out_ready;
  assign last_beat = (cnt == CNT_W'(BURST - 1));

  always_comb begin
    state_n = state;
    sel_n   = sel;
    gnt_n   = gnt;
    ptr_n   = ptr;
    cnt_n   = cnt;
    busy_n  = busy;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = BUSY;
          sel_n   = pick;
          gnt_n   = 8'd1 << pick;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end
      BUSY: begin
        // A dropped request ends the grant even if the burst is unfinished.
        if (!req[sel] || (accept && last_beat)) begin
          state_n = IDLE;
          gnt_n   = '0;
          busy_n  = 1'b0;
          cnt_n   = '0;
          ptr_n   = sel + 3'd1;
        end else if (accept) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      gnt   <= '0;
      ptr   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
    end
  end

endmodule
